// File: rtl/psram_qspi_ctrl.sv
// PSRAM serial engine: one SPI / QSPI / QPI transaction per accepted request.
// Parametrised address width, burst length, SCK divider and CE gap.
module psram_qspi_ctrl #(
    parameter int ADDR_W    = 24,
    parameter int MAX_BYTES = 4,
    parameter int DIV_W     = 4,
    parameter int CE_GAP    = 2,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_cmd,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [8*MAX_BYTES-1:0] req_wdata,
    input  logic [NB_W-1:0]        req_nbytes,
    input  logic                   req_rd,
    input  logic [3:0]             req_wait,
    input  logic [1:0]             req_mode,
    input  logic                   req_cmd_only,
    input  logic [DIV_W-1:0]       clk_div,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic                   busy,
    output logic                   sck,
    output logic                   ce_n,
    input  logic [3:0]             din,
    output logic [3:0]             dout,
    output logic [3:0]             douten
);
    localparam int DW   = 8 * MAX_BYTES;
    localparam int BMAX = (DW > ADDR_W) ? DW : ADDR_W;
    localparam int BC_W = $clog2(BMAX + 1);
    localparam int GC_W = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, GAP} state_t;

    state_t            state;
    state_t            st_nx;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [NB_W-1:0]   nb_q;
    logic [3:0]        wait_q;
    logic              rd_q;
    logic              spi_q;
    logic              qpi_q;
    logic              co_q;
    logic [BC_W-1:0]   bcnt;
    logic [GC_W-1:0]   gcnt;
    logic [7:0]        cmd_sh;
    logic [7:0]        cmd_nx;
    logic [ADDR_W-1:0] addr_sh;
    logic [ADDR_W-1:0] addr_nx;
    logic [DW-1:0]     wd_sh;
    logic [DW-1:0]     wd_nx;
    logic [DW-1:0]     racc;
    logic [7:0]        rx_byte;
    logic [7:0]        rx_nx;
    logic              byte_done;
    logic              last_beat;
    logic              m_spi;
    logic              m_qpi;
    int                beats;
    int                bidx;

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign m_qpi     = (req_mode == 2'b10);
    assign m_spi     = !(req_mode == 2'b01 || m_qpi);

    // Write data is shifted out byte 0 first, so reorder it once at acceptance.
    function automatic logic [DW-1:0] tx_order(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            r[DW-1-8*k -: 8] = w[8*k +: 8];
        return r;
    endfunction

    // Pad drive for the beat about to start, as {douten, dout}.
    function automatic logic [7:0] drive(
        input state_t            st,
        input logic              spi,
        input logic              qpi,
        input logic              rd,
        input logic [7:0]        c,
        input logic [ADDR_W-1:0] a,
        input logic [DW-1:0]     w
    );
        logic [7:0] r;
        r = 8'h00;
        unique case (st)
            CMD:  r = qpi ? {4'hF, c[7:4]} : {4'h1, 3'b000, c[7]};
            ADDR: r = spi ? {4'h1, 3'b000, a[ADDR_W-1]}
                          : {4'hF, a[ADDR_W-1 -: 4]};
            WAIT: r = spi ? 8'h10 : 8'h00;
            DATA: begin
                if (rd)
                    r = spi ? 8'h10 : 8'h00;
                else
                    r = spi ? {4'h1, 3'b000, w[DW-1]} : {4'hF, w[DW-1 -: 4]};
            end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        beats = 1;
        unique case (state)
            CMD:     beats = qpi_q ? 2 : 8;
            ADDR:    beats = spi_q ? ADDR_W : ADDR_W / 4;
            WAIT:    beats = int'(wait_q);
            DATA:    beats = spi_q ? 8 * int'(nb_q) : 2 * int'(nb_q);
            default: beats = 1;
        endcase
        last_beat = (int'(bcnt) == beats - 1);

        st_nx = state;
        if (last_beat) begin
            unique case (state)
                CMD:     st_nx = co_q ? GAP : ADDR;
                ADDR:    st_nx = (rd_q && wait_q != '0) ? WAIT
                               : (nb_q != '0) ? DATA : GAP;
                WAIT:    st_nx = (nb_q != '0) ? DATA : GAP;
                default: st_nx = GAP;
            endcase
        end

        cmd_nx  = cmd_sh;
        addr_nx = addr_sh;
        wd_nx   = wd_sh;
        if (state == CMD)
            cmd_nx = qpi_q ? {cmd_sh[3:0], 4'h0} : {cmd_sh[6:0], 1'b0};
        if (state == ADDR)
            addr_nx = spi_q ? addr_sh << 1 : addr_sh << 4;
        if (state == DATA)
            wd_nx = spi_q ? wd_sh << 1 : wd_sh << 4;

        rx_nx     = spi_q ? {rx_byte[6:0], din[1]} : {rx_byte[3:0], din};
        byte_done = spi_q ? (bcnt[2:0] == 3'b111) : bcnt[0];
        bidx      = spi_q ? int'(bcnt >> 3) : int'(bcnt >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            cnt       <= '0;
            nb_q      <= '0;
            wait_q    <= '0;
            rd_q      <= 1'b0;
            spi_q     <= 1'b1;
            qpi_q     <= 1'b0;
            co_q      <= 1'b0;
            bcnt      <= '0;
            gcnt      <= '0;
            cmd_sh    <= '0;
            addr_sh   <= '0;
            wd_sh     <= '0;
            racc      <= '0;
            rx_byte   <= '0;
            sck       <= 1'b0;
            ce_n      <= 1'b1;
            dout      <= '0;
            douten    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        div_q   <= clk_div;
                        nb_q    <= req_nbytes;
                        wait_q  <= req_wait;
                        rd_q    <= req_rd;
                        spi_q   <= m_spi;
                        qpi_q   <= m_qpi;
                        co_q    <= req_cmd_only;
                        cmd_sh  <= req_cmd;
                        addr_sh <= req_addr;
                        wd_sh   <= tx_order(req_wdata);
                        racc    <= '0;
                        rx_byte <= '0;
                        cnt     <= '0;
                        bcnt    <= '0;
                        sck     <= 1'b0;
                        ce_n    <= 1'b0;
                        state   <= CMD;
                        {douten, dout} <= drive(CMD, m_spi, m_qpi, req_rd,
                                                req_cmd, req_addr,
                                                tx_order(req_wdata));
                    end
                end
                GAP: begin
                    if (int'(gcnt) == CE_GAP - 1)
                        state <= IDLE;
                    else
                        gcnt <= gcnt + GC_W'(1);
                end
                default: begin
                    if (cnt != div_q) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                            if (state == DATA && rd_q) begin
                                rx_byte <= rx_nx;
                                if (byte_done)
                                    racc[8*bidx +: 8] <= rx_nx;
                            end
                        end else begin
                            sck     <= 1'b0;
                            state   <= st_nx;
                            bcnt    <= last_beat ? '0 : bcnt + BC_W'(1);
                            cmd_sh  <= cmd_nx;
                            addr_sh <= addr_nx;
                            wd_sh   <= wd_nx;
                            {douten, dout} <= drive(st_nx, spi_q, qpi_q, rd_q,
                                                    cmd_nx, addr_nx, wd_nx);
                            // Final falling edge: release CE and report together.
                            if (st_nx == GAP) begin
                                ce_n      <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_rdata <= racc;
                                gcnt      <= '0;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Scoreboard bench for psram_qspi_ctrl: directed requests, pad-level monitor
// with a small PSRAM pin model feeding din.
module tb_psram_qspi_ctrl;
    localparam int ADDR_W    = 24;
    localparam int MAX_BYTES = 4;
    localparam int DIV_W     = 4;
    localparam int CE_GAP    = 2;
    localparam int NB_W      = 3;
    localparam int DW        = 32;
    localparam int NBT       = 96;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [7:0]        req_cmd = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic [NB_W-1:0]   req_nbytes = '0;
    logic              req_rd = 1'b0;
    logic [3:0]        req_wait = '0;
    logic [1:0]        req_mode = '0;
    logic              req_cmd_only = 1'b0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              busy;
    logic              sck;
    logic              ce_n;
    logic [3:0]        din = '0;
    logic [3:0]        dout;
    logic [3:0]        douten;

    always #5 clk = ~clk;

    psram_qspi_ctrl #(
        .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .DIV_W(DIV_W),
        .CE_GAP(CE_GAP), .NB_W(NB_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_nbytes(req_nbytes), .req_rd(req_rd), .req_wait(req_wait),
        .req_mode(req_mode), .req_cmd_only(req_cmd_only), .clk_div(clk_div),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sck(sck), .ce_n(ce_n), .din(din), .dout(dout), .douten(douten)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  e_out [8][NBT];
    logic [3:0]  din_s [8][NBT];
    int          e_beats [8];
    int          e_low [8];
    logic [31:0] e_rdata [8];
    bit          e_gap [8];
    int          exp_q [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected pad activity per beat as {douten, dout & douten}, plus din stream.
    task automatic build(input int id, input logic [7:0] cmd,
                         input logic [23:0] addr, input logic [31:0] wd,
                         input int nb, input bit rd, input int wt,
                         input logic [1:0] mode, input bit co,
                         input logic [31:0] chip);
        int b;
        bit spi;
        bit qpi;
        spi = (mode == 2'b00) || (mode == 2'b11);
        qpi = (mode == 2'b10);
        for (int i = 0; i < NBT; i++) begin
            e_out[id][i] = 8'h00;
            din_s[id][i] = 4'h0;
        end
        b = 0;
        if (qpi) begin
            for (int i = 0; i < 2; i++) begin
                e_out[id][b] = {4'hF, cmd[7-4*i -: 4]}; b++;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                e_out[id][b] = {4'h1, 3'b000, cmd[7-i]}; b++;
            end
        end
        if (!co) begin
            if (spi) begin
                for (int i = 0; i < 24; i++) begin
                    e_out[id][b] = {4'h1, 3'b000, addr[23-i]}; b++;
                end
            end else begin
                for (int i = 0; i < 6; i++) begin
                    e_out[id][b] = {4'hF, addr[23-4*i -: 4]}; b++;
                end
            end
            if (rd) begin
                for (int i = 0; i < wt; i++) begin
                    e_out[id][b] = spi ? 8'h10 : 8'h00; b++;
                end
            end
            for (int k = 0; k < nb; k++) begin
                if (spi) begin
                    for (int j = 0; j < 8; j++) begin
                        if (rd) begin
                            e_out[id][b] = 8'h10;
                            din_s[id][b] = {2'b00, chip[8*k+7-j], 1'b0};
                        end else begin
                            e_out[id][b] = {4'h1, 3'b000, wd[8*k+7-j]};
                        end
                        b++;
                    end
                end else begin
                    for (int j = 0; j < 2; j++) begin
                        if (rd) begin
                            e_out[id][b] = 8'h00;
                            din_s[id][b] = chip[8*k+7-4*j -: 4];
                        end else begin
                            e_out[id][b] = {4'hF, wd[8*k+7-4*j -: 4]};
                        end
                        b++;
                    end
                end
            end
        end
    endtask

    task automatic set_req(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [31:0] wd, input int nb, input bit rd,
                           input int wt, input logic [1:0] mode, input bit co,
                           input int div);
        req_cmd      = cmd;
        req_addr     = addr;
        req_wdata    = wd;
        req_nbytes   = NB_W'(nb);
        req_rd       = rd;
        req_wait     = 4'(wt);
        req_mode     = mode;
        req_cmd_only = co;
        clk_div      = DIV_W'(div);
    endtask

    task automatic wait_accept(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: accept timeout, got busy expected ready", nm);
        end
    endtask

    task automatic run(input int id, input logic [7:0] cmd,
                       input logic [23:0] addr, input logic [31:0] wd,
                       input int nb, input bit rd, input int wt,
                       input logic [1:0] mode, input bit co, input int div,
                       input logic [31:0] chip, input int beats,
                       input int low, input logic [31:0] rdata,
                       input bit push);
        build(id, cmd, addr, wd, nb, rd, wt, mode, co, chip);
        e_beats[id] = beats;
        e_low[id]   = low;
        e_rdata[id] = rdata;
        e_gap[id]   = 1'b0;
        if (push) exp_q.push_back(id);
        set_req(cmd, addr, wd, nb, rd, wt, mode, co, div);
        req_valid = 1'b1;
        wait_accept($sformatf("t%0d", id));
        req_valid = 1'b0;
    endtask

    // Pad monitor / scoreboard consumer
    int  cyc = 0;
    int  rise_cyc = 0;
    int  cur = -1;
    int  low = 0;
    int  rises = 0;
    int  rcnt = 0;
    bit  in_txn = 1'b0;
    bit  pend = 1'b0;
    logic psck = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_txn = 1'b0;
            pend   = 1'b0;
            psck   = 1'b0;
            din    = 4'h0;
        end else begin
            if (sck && ce_n) chk("sck_while_ce_high", 1, 0);
            if (pend) begin
                rcnt++;
                if (req_ready) begin
                    chk($sformatf("t%0d ready_gap", cur), rcnt, CE_GAP);
                    pend = 1'b0;
                end
            end
            if (!ce_n) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    low    = 0;
                    rises  = 0;
                    cur    = (exp_q.size() > 0) ? exp_q[0] : -1;
                    if (cur >= 0 && e_gap[cur])
                        chk($sformatf("t%0d ce_gap", cur), cyc - rise_cyc, CE_GAP + 1);
                end
                low++;
                if (sck && !psck) begin
                    if (cur >= 0 && rises < NBT)
                        chk($sformatf("t%0d beat%0d", cur, rises),
                            {douten, dout & douten}, e_out[cur][rises]);
                    rises++;
                end
                din = (cur >= 0 && rises < NBT) ? din_s[cur][rises] : 4'h0;
                if (rsp_valid) chk("rsp_valid_early", 1, 0);
            end else begin
                if (in_txn) begin
                    in_txn   = 1'b0;
                    rise_cyc = cyc;
                    pend     = 1'b1;
                    rcnt     = 0;
                    din      = 4'h0;
                    if (cur < 0) begin
                        chk("unexpected_txn", 1, 0);
                    end else begin
                        void'(exp_q.pop_front());
                        chk($sformatf("t%0d rsp_valid", cur), rsp_valid, 1);
                        chk($sformatf("t%0d rdata", cur), rsp_rdata, e_rdata[cur]);
                        chk($sformatf("t%0d ce_low", cur), low, e_low[cur]);
                        chk($sformatf("t%0d beats", cur), rises, e_beats[cur]);
                    end
                end else if (rsp_valid) begin
                    chk("rsp_valid_spurious", 1, 0);
                end
            end
            psck = sck;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst ce_n", ce_n, 1);
        chk("rst sck", sck, 0);
        chk("rst dout", dout, 0);
        chk("rst douten", douten, 0);
        chk("rst req_ready", req_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // QPI read 4 bytes, wait 6, din nibbles 1..8
        run(0, 8'hEB, 24'h123456, 32'h0, 4, 1, 6, 2'b10, 0, 0,
            32'h78563412, 22, 44, 32'h78563412, 1);
        // SPI write 1 byte, wait ignored for writes
        run(1, 8'h02, 24'h000100, 32'h000000A5, 1, 0, 3, 2'b00, 0, 1,
            32'h0, 40, 160, 32'h0, 1);
        // QSPI read 2 bytes, no wait; upper rdata bytes must be zero
        run(2, 8'hEB, 24'hABCDEF, 32'h0, 2, 1, 0, 2'b01, 0, 0,
            32'h1122C35A, 18, 36, 32'h0000C35A, 1);
        // SPI command only; rd/wait/nbytes ignored
        run(3, 8'h35, 24'hFFFFFF, 32'hFFFFFFFF, 4, 1, 5, 2'b00, 1, 2,
            32'hFFFFFFFF, 8, 48, 32'h0, 1);
        // QSPI read with zero bytes: wait phase only
        run(4, 8'h6B, 24'h0F0F0F, 32'h0, 0, 1, 4, 2'b01, 0, 1,
            32'hFFFFFFFF, 18, 72, 32'h0, 1);

        // Back-to-back with req_valid held; second is reserved mode (SPI)
        build(5, 8'h38, 24'h0ABCDE, 32'h0000BEEF, 2, 0, 0, 2'b10, 0, 32'h0);
        e_beats[5] = 12; e_low[5] = 24; e_rdata[5] = 32'h0; e_gap[5] = 1'b0;
        exp_q.push_back(5);
        set_req(8'h38, 24'h0ABCDE, 32'h0000BEEF, 2, 0, 0, 2'b10, 0, 0);
        req_valid = 1'b1;
        wait_accept("t5");
        build(6, 8'h03, 24'h000010, 32'h0, 1, 1, 0, 2'b11, 0, 32'hFFFFFF96);
        e_beats[6] = 40; e_low[6] = 80; e_rdata[6] = 32'h00000096; e_gap[6] = 1'b1;
        exp_q.push_back(6);
        set_req(8'h03, 24'h000010, 32'h0, 1, 1, 0, 2'b11, 0, 0);
        wait_accept("t6");
        req_valid = 1'b0;

        // SPI read aborted by reset in the data phase: no response expected
        run(7, 8'h03, 24'h000200, 32'h0, 4, 1, 0, 2'b00, 0, 0,
            32'h0, 0, 0, 32'h0, 0);
        repeat (80) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort ce_n", ce_n, 1);
        chk("abort sck", sck, 0);
        chk("abort douten", douten, 0);
        chk("abort rsp_rdata", rsp_rdata, 0);
        chk("abort req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Normal QPI read after the abort
        run(7, 8'hEB, 24'h00FACE, 32'h0, 4, 1, 2, 2'b10, 0, 3,
            32'hDEADBEEF, 18, 144, 32'hDEADBEEF, 1);

        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
